tx_mux_serial: RTL and testbench

TX_MUX_SERIAL -- requirements
Module: tx_mux_serial

---
 rtl/tx_mux_serial.sv | 156 +++++++++++++++
 tb/tb_tx_mux_serial.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tx_mux_serial.sv
// rtl/tx_mux_serial.sv - four-lane TDM byte multiplexer onto an MSB-first serial stream with comma sync.
// Optional byte counter on tx_count is built when TX_BYTECNT_EN is defined.
module tx_mux_serial #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_BYTES = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  input  logic        valid_in0,
  input  logic        valid_in1,
  input  logic        valid_in2,
  input  logic        valid_in3,
  output logic        ready_in0,
  output logic        ready_in1,
  output logic        ready_in2,
  output logic        ready_in3,
  output logic        data_out,
  output logic        byte_start,
  output logic [1:0]  slot_lane,
  output logic        active,
  output logic        comma_collision,
  output logic [15:0] tx_count
);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q;
  logic [0:0]       state_q, state_d;
  logic [3:0]       sync_cnt_q, sync_cnt_d;
  logic [1:0]       lane_q, cur_lane_q;
  logic [3:0]       full_q, full_d;
  logic [3:0][7:0]  hold_q, hold_d;
  logic             collision_q, collision_d;

  logic [3:0][7:0]  in_w;
  logic [3:0]       valid_w, ready_w, accept_w, unload_w, slot_hit_w;
  logic             boundary, sync_done, load_slot, slot_has_data;
  logic [7:0]       slot_byte;

  assign in_w    = {in3, in2, in1, in0};
  assign valid_w = {valid_in3, valid_in2, valid_in1, valid_in0};

  assign boundary  = (bit_cnt_q == 3'd7);
  assign sync_done = (state_q == ST_SYNC) && boundary && (sync_cnt_q == SYNC_LAST);
  // The boundary that ends the last sync comma already loads the lane 0 slot.
  assign load_slot = boundary && ((state_q == ST_DATA) || sync_done);

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      slot_hit_w[n] = load_slot && (lane_q == 2'(n));
      unload_w[n]   = slot_hit_w[n] && full_q[n];
      ready_w[n]    = !full_q[n] || unload_w[n];
      accept_w[n]   = valid_w[n] && ready_w[n] && !reset;
    end
  end

  assign ready_in0 = ready_w[0];
  assign ready_in1 = ready_w[1];
  assign ready_in2 = ready_w[2];
  assign ready_in3 = ready_w[3];

  // An empty lane accepting at its own boundary bypasses the holding register.
  always_comb begin
    slot_byte     = COMMA;
    slot_has_data = 1'b0;
    if (full_q[lane_q]) begin
      slot_byte     = hold_q[lane_q];
      slot_has_data = 1'b1;
    end else if (accept_w[lane_q]) begin
      slot_byte     = in_w[lane_q];
      slot_has_data = 1'b1;
    end
  end

  always_comb begin
    full_d      = full_q;
    hold_d      = hold_q;
    collision_d = collision_q;
    for (int n = 0; n < 4; n++) begin
      if (accept_w[n] && !(slot_hit_w[n] && !full_q[n])) begin
        hold_d[n] = in_w[n];
        full_d[n] = 1'b1;
      end else if (unload_w[n]) begin
        full_d[n] = 1'b0;
      end
      if (accept_w[n] && (in_w[n] == COMMA)) collision_d = 1'b1;
    end
  end

  always_comb begin
    shreg_d    = {shreg_q[6:0], 1'b0};
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    if (boundary) begin
      shreg_d = load_slot ? slot_byte : COMMA;
      if (state_q == ST_SYNC) sync_cnt_d = sync_cnt_q + 4'd1;
      if (sync_done) state_d = ST_DATA;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shreg_q     <= COMMA;
      bit_cnt_q   <= 3'd0;
      state_q     <= ST_SYNC;
      sync_cnt_q  <= 4'd0;
      lane_q      <= 2'd0;
      cur_lane_q  <= 2'd0;
      full_q      <= 4'b0000;
      hold_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_q + 3'd1;
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      collision_q <= collision_d;
      if (load_slot) begin
        lane_q     <= lane_q + 2'd1;
        cur_lane_q <= lane_q;
      end
    end
  end

`ifdef TX_BYTECNT_EN
  logic [15:0] tx_count_q;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      tx_count_q <= 16'h0000;
    end else if (load_slot && slot_has_data) begin
      tx_count_q <= tx_count_q + 16'h0001;
    end
  end

  assign tx_count = tx_count_q;
`else
  assign tx_count = 16'h0000;
`endif

  assign data_out        = shreg_q[7];
  assign byte_start      = (bit_cnt_q == 3'd0);
  assign slot_lane       = cur_lane_q;
  assign active          = (state_q == ST_DATA);
  assign comma_collision = collision_q;

endmodule

// File: tb/tb_tx_mux_serial.sv
// tb/tb_tx_mux_serial.sv - directed self-checking bench for tx_mux_serial.
module tb_tx_mux_serial;

  logic        clk_32f;
  logic        reset;
  logic [7:0]  in0, in1, in2, in3;
  logic        valid_in0, valid_in1, valid_in2, valid_in3;
  logic        ready_in0, ready_in1, ready_in2, ready_in3;
  logic        data_out, byte_start, active, comma_collision;
  logic [1:0]  slot_lane;
  logic [15:0] tx_count;

  int checks   = 0;
  int failures = 0;

  tx_mux_serial dut (
    .clk_32f(clk_32f), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
    .ready_in0(ready_in0), .ready_in1(ready_in1), .ready_in2(ready_in2), .ready_in3(ready_in3),
    .data_out(data_out), .byte_start(byte_start), .slot_lane(slot_lane), .active(active),
    .comma_collision(comma_collision), .tx_count(tx_count)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of bit 0 of a byte; returns at bit 0 of the next byte.
  task automatic expect_byte(input string tag, input logic [7:0] eb, input logic [1:0] el,
                             input logic ea);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        chk({tag, "_byte_start"}, {31'd0, byte_start}, 32'd1);
        chk({tag, "_lane"}, {30'd0, slot_lane}, {30'd0, el});
        chk({tag, "_active"}, {31'd0, active}, {31'd0, ea});
      end
      if (i == 1) begin
        chk({tag, "_byte_start_low"}, {31'd0, byte_start}, 32'd0);
        valid_in0 = 1'b0;
        valid_in2 = 1'b0;
      end
      b = {b[6:0], data_out};
      @(negedge clk_32f);
    end
    chk({tag, "_data"}, {24'd0, b}, {24'd0, eb});
  endtask

  logic [7:0]  c_bits [80];
  logic        c_bs   [80];
  logic [1:0]  c_lane [80];
  logic [7:0]  exp_c  [10];
  logic [7:0]  vals   [3];
  logic [7:0]  got;
  logic        acc_pend;
  int          idx;
  logic [15:0] exp_cnt;

  initial begin
    reset = 1'b1;
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
    valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;

    // Idle stream: four sync commas then four idle slots
    chk("rst_data_out", {31'd0, data_out}, 32'd1);
    chk("rst_ready", {28'd0, ready_in3, ready_in2, ready_in1, ready_in0}, 32'hF);
    chk("rst_tx_count", {16'd0, tx_count}, 32'd0);
    chk("rst_collision", {31'd0, comma_collision}, 32'd0);
    for (int k = 0; k < 4; k++) expect_byte("idle_sync", 8'hBC, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) expect_byte("idle_data", 8'hBC, 2'(k), 1'b1);

    // Restart; load lanes 0 and 2 during the last sync byte
    reset = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) expect_byte("tr_sync", 8'hBC, 2'd0, 1'b0);
    in0 = 8'hA5; valid_in0 = 1'b1;
    in2 = 8'h3C; valid_in2 = 1'b1;
    expect_byte("tr_sync3", 8'hBC, 2'd0, 1'b0);
    expect_byte("tr_s0", 8'hA5, 2'd0, 1'b1);
    expect_byte("tr_s1", 8'hBC, 2'd1, 1'b1);
    expect_byte("tr_s2", 8'h3C, 2'd2, 1'b1);
    expect_byte("tr_s3", 8'hBC, 2'd3, 1'b1);
`ifdef TX_BYTECNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    chk("tr_tx_count", {16'd0, tx_count}, {16'd0, exp_cnt});
    chk("tr_collision", {31'd0, comma_collision}, 32'd0);

    // Lane 1 streams 01,02,03 under backpressure; lane 3 sends a comma-valued byte by bypass
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
    idx = 0;
    in1 = vals[0]; valid_in1 = 1'b1;
    acc_pend = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (acc_pend) begin
        idx++;
        if (idx == 3) valid_in1 = 1'b0;
        else in1 = vals[idx];
      end
      c_bits[c] = {7'd0, data_out};
      c_bs[c]   = byte_start;
      c_lane[c] = slot_lane;
      if (c == 1) chk("bp_ready1_drop", {31'd0, ready_in1}, 32'd0);
      if (c == 23) begin
        chk("col_before", {31'd0, comma_collision}, 32'd0);
        in3 = 8'hBC; valid_in3 = 1'b1;
      end
      if (c == 24) begin
        chk("col_after", {31'd0, comma_collision}, 32'd1);
        valid_in3 = 1'b0;
      end
      acc_pend = valid_in1 && ready_in1;
      @(negedge clk_32f);
    end
    exp_c[0] = 8'hBC; exp_c[1] = 8'h01; exp_c[2] = 8'hBC; exp_c[3] = 8'hBC; exp_c[4] = 8'hBC;
    exp_c[5] = 8'h02; exp_c[6] = 8'hBC; exp_c[7] = 8'hBC; exp_c[8] = 8'hBC; exp_c[9] = 8'h03;
    for (int j = 0; j < 10; j++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) got = {got[6:0], c_bits[8*j+i][0]};
      chk($sformatf("bp_byte%0d", j), {24'd0, got}, {24'd0, exp_c[j]});
      chk($sformatf("bp_lane%0d", j), {30'd0, c_lane[8*j]}, 32'(j % 4));
      chk($sformatf("bp_bs%0d", j), {31'd0, c_bs[8*j]}, 32'd1);
    end
    chk("bp_accepts", 32'(idx), 32'd3);
`ifdef TX_BYTECNT_EN
    exp_cnt = 16'd6;
`else
    exp_cnt = 16'd0;
`endif
    chk("bp_tx_count", {16'd0, tx_count}, {16'd0, exp_cnt});
    chk("col_sticky", {31'd0, comma_collision}, 32'd1);

    // Hold a lane 0 byte, then reset mid-byte at bit_cnt 4 with valid high
    in0 = 8'h77; valid_in0 = 1'b1;
    @(negedge clk_32f);
    valid_in0 = 1'b0;
    chk("mid_ready0_full", {31'd0, ready_in0}, 32'd0);
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    in1 = 8'h55; valid_in1 = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
    valid_in1 = 1'b0;
    chk("mid_data_out", {31'd0, data_out}, 32'd1);
    chk("mid_active", {31'd0, active}, 32'd0);
    chk("mid_ready", {28'd0, ready_in3, ready_in2, ready_in1, ready_in0}, 32'hF);
    chk("mid_collision", {31'd0, comma_collision}, 32'd0);
    chk("mid_tx_count", {16'd0, tx_count}, 32'd0);
    for (int k = 0; k < 4; k++) expect_byte("mid_sync", 8'hBC, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) expect_byte("mid_data", 8'hBC, 2'(k), 1'b1);
    chk("mid_tx_count_end", {16'd0, tx_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
